// File: rtl/fft_32_frame_sequencer.sv
// fft_32_frame_sequencer: collects a 32-sample frame, runs the FFT for RUN_CYCLES, streams the 32 results out (FFT_SEQ_BITREV_EN selects bit-reversed frame writes; err_len is registered and pulses the cycle after the offending beat)
module fft_32_frame_sequencer #(
  parameter int fix_bit    = 7,
  parameter int bits       = 16,
  parameter int RUN_CYCLES = 10
) (
  input  logic                 clk_100,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [2*bits-1:0]    s_data,
  input  logic                 s_last,
  output logic [64*bits-1:0]   fft_in,
  input  logic [64*bits-1:0]   fft_out,
  output logic [3:0]           fft_en,
  output logic [1:0]           fft_sel,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2*bits-1:0]    m_data,
  output logic [4:0]           m_index,
  output logic                 m_last,
  output logic                 busy,
  output logic                 err_len
);
  localparam int SW = 2*bits + 0*fix_bit;
  localparam int RW = $clog2(RUN_CYCLES) < 2 ? 2 : $clog2(RUN_CYCLES);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [4:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic [64*bits-1:0] frame_q, frame_d, out_q, out_d;
  logic err_q, err_d;
  logic accept, fin;
  function automatic logic [4:0] slot(input logic [4:0] k);
`ifdef FFT_SEQ_BITREV_EN
    return {k[0], k[1], k[2], k[3], k[4]};
`else
    return k;
`endif
  endfunction
  assign accept  = s_valid && s_ready;
  assign s_ready = state_q == IDLE || state_q == LOAD;
  assign busy    = state_q != IDLE;
  assign fft_en  = state_q == RUN ? 4'hF : 4'h0;
  assign fft_sel = state_q == RUN ? run_cnt_q[1:0] : 2'd0;
  assign m_valid = state_q == DRAIN;
  assign m_data  = m_valid ? out_q[rd_ptr_q*SW +: SW] : '0;
  assign m_index = m_valid ? rd_ptr_q : 5'd0;
  assign m_last  = m_valid && rd_ptr_q == 5'd31;
  assign fft_in  = frame_q;
  assign err_len = err_q;
  // next-state: frame loading with zero-fill, run window count, result capture and drain
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    run_cnt_d = run_cnt_q;
    frame_d   = frame_q;
    out_d     = out_q;
    err_d     = 1'b0;
    fin       = 1'b0;
    case (state_q)
      IDLE, LOAD: if (accept) begin
        frame_d[slot(wr_ptr_q)*SW +: SW] = s_data;
        for (int j = 0; j < 32; j++)
          if (s_last && 5'(j) > wr_ptr_q) frame_d[slot(5'(j))*SW +: SW] = '0;
        fin      = s_last || wr_ptr_q == 5'd31;
        err_d    = s_last ^ (wr_ptr_q == 5'd31);
        wr_ptr_d = fin ? 5'd0 : wr_ptr_q + 5'd1;
        state_d  = fin ? RUN : LOAD;
      end
      RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (run_cnt_q == RW'(RUN_CYCLES-1)) begin
          out_d     = fft_out;
          run_cnt_d = '0;
          state_d   = DRAIN;
        end
      end
      DRAIN: if (m_ready) begin
        rd_ptr_d = rd_ptr_q + 5'd1;
        state_d  = rd_ptr_q == 5'd31 ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and buffer registers, cleared asynchronously
  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      run_cnt_q <= '0;
      frame_q   <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      run_cnt_q <= run_cnt_d;
      frame_q   <= frame_d;
      out_q     <= out_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_fft_32_frame_sequencer.sv
// tb_fft_32_frame_sequencer: random and directed frames checked every cycle against a frame-level model
module tb_fft_32_frame_sequencer;
  localparam int BITS = 16, RC = 10, W = 2*BITS;
  logic clk_100 = 1'b0, reset = 1'b1, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic s_ready, m_valid, m_last, busy, err_len;
  logic [W-1:0] s_data = '0, m_data;
  logic [32*W-1:0] fft_in, fft_out;
  logic [3:0] fft_en;
  logic [1:0] fft_sel;
  logic [4:0] m_index;
  logic [7:0] cyc = 8'd0;
  int pass_cnt = 0, total = 0, errs = 0, beats = 0;
  bit rnd_ready = 1'b0;
  logic [W-1:0] got[$];
  logic [W-1:0] ef[32], eo[32];
  int run_idx = -1, drain_idx = -1, n_got;
  bit err_e = 1'b0, nerr;

  fft_32_frame_sequencer #(.fix_bit(7), .bits(BITS), .RUN_CYCLES(RC)) dut (
    .clk_100(clk_100), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .fft_in(fft_in), .fft_out(fft_out), .fft_en(fft_en), .fft_sel(fft_sel),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last),
    .busy(busy), .err_len(err_len));

  always #5 clk_100 = ~clk_100;
  always @(posedge clk_100) cyc <= cyc + 8'd1;

  // FFT stub: reversed bins, tagged with bin number and the capture-cycle stamp
  always_comb begin
    fft_out = '0;
    for (int k = 0; k < 32; k++) fft_out[k*W +: W] = fft_in[(31-k)*W +: W] ^ {cyc, 8'(k), 16'h5A3C};
  end

  function automatic int slot(input int k);
`ifdef FFT_SEQ_BITREV_EN
    int r = 0;
    for (int b = 0; b < 5; b++) if (((k >> b) & 1) == 1) r += 1 << (4 - b);
    return r;
`else
    return k;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // per-cycle compare against the frame model, then advance the model by one cycle
  always @(negedge clk_100) begin
    int bad;
    if (!reset) begin
      got.delete();
      foreach (ef[k]) begin ef[k] = '0; eo[k] = '0; end
      run_idx = -1; drain_idx = -1; err_e = 1'b0;
    end
    chk("s_ready", s_ready, run_idx < 0 && drain_idx < 0);
    chk("busy", busy, run_idx >= 0 || drain_idx >= 0 || got.size() > 0);
    chk("fft_en", fft_en, run_idx >= 0 ? 4'hF : 4'h0);
    chk("fft_sel", fft_sel, run_idx >= 0 ? run_idx % 4 : 0);
    chk("m_valid", m_valid, drain_idx >= 0);
    chk("m_data", m_data, drain_idx >= 0 ? eo[drain_idx] : '0);
    chk("m_index", m_index, drain_idx >= 0 ? drain_idx : 0);
    chk("m_last", m_last, drain_idx == 31);
    chk("err_len", err_len, err_e);
    bad = 0;
    for (int k = 31; k >= 0; k--) if (fft_in[k*W +: W] !== ef[k]) bad = k;
    chk("fft_in", fft_in[bad*W +: W], ef[bad]);
    if (err_len) errs++;
    if (reset) begin
      if (m_valid && m_ready) beats++;
      nerr = 1'b0;
      if (run_idx < 0 && drain_idx < 0) begin
        if (s_valid) begin
          got.push_back(s_data);
          n_got = got.size();
          ef[slot(n_got-1)] = s_data;
          if (s_last || n_got == 32) begin
            nerr = !(s_last && n_got == 32);
            for (int k = n_got; k < 32; k++) ef[slot(k)] = '0;
            got.delete();
            run_idx = 0;
          end
        end
      end else if (run_idx >= 0) begin
        if (run_idx == RC-1) begin
          for (int k = 0; k < 32; k++) eo[k] = ef[31-k] ^ {cyc, 8'(k), 16'h5A3C};
          run_idx = -1; drain_idx = 0;
        end else run_idx++;
      end else if (m_ready) drain_idx = drain_idx == 31 ? -1 : drain_idx + 1;
      err_e = nerr;
    end
  end

  initial forever begin
    @(posedge clk_100); #1;
    m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic [W-1:0] d, input bit last);
    bit acc = 1'b0;
    int g = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!acc && g < 400) begin
      @(negedge clk_100); acc = s_ready; g++;
      @(posedge clk_100); #1;
    end
    chk("send_timeout", acc, 1);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic frame(input int n, input bit last, input bit directed, input int base);
    for (int k = 0; k < n; k++) begin
      if (!directed && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk_100);
        #1;
      end
      send(directed ? {16'(k + base), 16'h0} : W'($urandom), last && k == n-1);
    end
  endtask

  task automatic wait_mv(input int sa, input int sb, output int lat, output logic [W-1:0] va,
                         output logic [W-1:0] vb, output logic [3:0] en1, output logic rdy1);
    lat = 0; va = '0; vb = '0; en1 = '0; rdy1 = 1'b0;
    do begin
      lat++;
      @(negedge clk_100);
      if (lat == 1) begin en1 = fft_en; rdy1 = s_ready; end
      if (lat == 2) begin va = fft_in[sa*W +: W]; vb = fft_in[sb*W +: W]; end
    end while (!m_valid && lat < 200);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 2000) begin @(posedge clk_100); #1; g++; end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    int lat, e0, b0, n, g;
    logic [W-1:0] va, vb;
    logic [3:0] en1;
    logic rdy1;
    bit l;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk_100);
    #1 reset = 1'b1;
    e0 = errs; b0 = beats;
    frame(32, 1'b1, 1'b1, 0);
    wait_mv(slot(1), slot(31), lat, va, vb, en1, rdy1);
    chk("t1_latency", lat, RC + 1);
    chk("t1_slot_of_1", va, 32'h0001_0000);
    chk("t1_slot_of_31", vb, 32'h001F_0000);
    chk("t1_bin0", m_data[23:0], 24'h1F5A3C);
    chk("t1_idx0", m_index, 0);
    @(posedge clk_100); #1;
    wait_idle();
    chk("t1_err", errs - e0, 0);
    chk("t1_beats", beats - b0, 32);
    e0 = errs; b0 = beats;
    frame(5, 1'b1, 1'b1, 100);
    wait_mv(slot(4), slot(5), lat, va, vb, en1, rdy1);
    chk("t2_slot_of_4", va, 32'h0068_0000);
    chk("t2_zero_fill", vb, 0);
    chk("t2_latency", lat, RC + 1);
    @(posedge clk_100); #1;
    wait_idle();
    chk("t2_err", errs - e0, 1);
    chk("t2_beats", beats - b0, 32);
    e0 = errs;
    frame(32, 1'b0, 1'b1, 200);
    wait_mv(slot(0), slot(31), lat, va, vb, en1, rdy1);
    chk("t3_run_next", en1, 4'hF);
    chk("t3_ready_low", rdy1, 0);
    chk("t3_slot_of_31", vb, 32'h00E7_0000);
    @(posedge clk_100); #1;
    wait_idle();
    chk("t3_err", errs - e0, 1);
    rnd_ready = 1'b1;
    repeat (6) begin
      n = $urandom_range(1, 32);
      l = n < 32 ? 1'b1 : 1'($urandom_range(0, 1));
      frame(n, l, 1'b0, 0);
    end
    wait_idle();
    frame(10, 1'b0, 1'b0, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk_100);
    #1 reset = 1'b1;
    chk("rst_load_ready", s_ready, 1);
    chk("rst_load_busy", busy, 0);
    b0 = beats;
    frame(32, 1'b1, 1'b0, 0);
    wait_idle();
    chk("post_load_rst_beats", beats - b0, 32);
    frame(32, 1'b1, 1'b0, 0);
    g = 0;
    while (!(m_valid && m_index >= 5) && g < 500) begin @(posedge clk_100); #1; g++; end
    chk("drain_reached", m_valid, 1);
    reset = 1'b0;
    repeat (2) @(posedge clk_100);
    #1 reset = 1'b1;
    chk("rst_drain_ready", s_ready, 1);
    chk("rst_drain_mvalid", m_valid, 0);
    rnd_ready = 1'b0;
    frame(32, 1'b1, 1'b1, 0);
    wait_mv(slot(1), slot(31), lat, va, vb, en1, rdy1);
    chk("t6_bin0", m_data[23:0], 24'h1F5A3C);
    chk("t6_latency", lat, RC + 1);
    @(posedge clk_100); #1;
    wait_idle();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
